// File: rtl/esc_mode_controller.sv
// Purpose : escape-mode controller for the C-PHY LP transmitter. It arbitrates PPI escape
//           requests, runs LP escape entry, drives the one-hot serializer command select,
//           serializes LPDT bytes or holds ULPS, and then runs escape exit (Mark-1, Stop).
// Latency : all outputs are registered. The first entry LP state appears one edge after
//           the request is sampled. Each entry state lasts ENTRY_CYC cycles and Mark-1
//           lasts EXIT_CYC cycles.
// Backpres: the controller waits indefinitely for CmdDone. A byte is taken only when the
//           shifter is empty and TxValidEsc=1, and the TxReadyEsc pulse acknowledges it.
// Ports   : TxClkEsc/RstN    clock and asynchronous active-low reset
//           TxRequestEsc, TxUlpsEsc, TxLpdtEsc, TxTriggerEsc   PPI escape request and selection
//           TxDataEsc, TxValidEsc, TxReadyEsc                  LPDT byte handshake
//           CmdDone, EscSeqCtr, SeqSel                         command serializer interface
//           LpState, PayBit, PayActive                         LP line drive
//           UlpsActiveNot, Stopstate                           PPI status
module esc_mode_controller #(
  parameter int ENTRY_CYC = 2,
  parameter int EXIT_CYC  = 2
) (
  input  logic       TxClkEsc,
  input  logic       RstN,
  input  logic       TxRequestEsc,
  input  logic       TxUlpsEsc,
  input  logic       TxLpdtEsc,
  input  logic [3:0] TxTriggerEsc,
  input  logic [7:0] TxDataEsc,
  input  logic       TxValidEsc,
  output logic       TxReadyEsc,
  input  logic       CmdDone,
  output logic [7:0] EscSeqCtr,
  output logic [1:0] LpState,
  output logic       SeqSel,
  output logic       PayBit,
  output logic       PayActive,
  output logic       UlpsActiveNot,
  output logic       Stopstate
);

  localparam int CW = $clog2(((ENTRY_CYC > EXIT_CYC) ? ENTRY_CYC : EXIT_CYC) + 1);
  localparam logic [CW-1:0] ENT_LAST  = CW'(ENTRY_CYC - 1);
  localparam logic [CW-1:0] EXIT_LAST = CW'(EXIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, ENT_10, ENT_00A, ENT_01, ENT_00B, CMD, PAYLOAD, ULPS, EXIT_10
  } state_t;

  state_t        state, stateNx;
  logic [7:0]    grant, grantNx, selGrant;
  logic [CW-1:0] cnt, cntNx;
  logic          reqLost, reqLostNx;   // request dropped during entry/CMD
  logic [7:0]    shReg, shRegNx;
  logic [2:0]    bitCnt, bitCntNx;     // bits still to shift after the one on the line
  logic          payBitNx, readyNx;
  logic [1:0]    lpNx;

  // Fixed-priority grant: ULPS > LPDT > trigger 0..3.
  always_comb begin
    selGrant = 8'h00;
    if      (TxUlpsEsc)       selGrant = 8'b0000_0010;
    else if (TxLpdtEsc)       selGrant = 8'b0000_0001;
    else if (TxTriggerEsc[0]) selGrant = 8'b0000_0100;
    else if (TxTriggerEsc[1]) selGrant = 8'b0000_1000;
    else if (TxTriggerEsc[2]) selGrant = 8'b0001_0000;
    else if (TxTriggerEsc[3]) selGrant = 8'b0010_0000;
  end

  always_comb begin
    stateNx   = state;
    grantNx   = grant;
    cntNx     = '0;
    reqLostNx = reqLost;
    shRegNx   = shReg;
    bitCntNx  = bitCnt;
    payBitNx  = PayBit;
    readyNx   = 1'b0;
    unique case (state)
      IDLE: begin
        reqLostNx = 1'b0;
        bitCntNx  = 3'd0;
        if (TxRequestEsc && (selGrant != 8'h00)) begin
          grantNx = selGrant;
          stateNx = ENT_10;
        end
      end
      ENT_10, ENT_00A, ENT_01, ENT_00B: begin
        if (!TxRequestEsc) reqLostNx = 1'b1;
        if (cnt == ENT_LAST) begin
          unique case (state)
            ENT_10:  stateNx = ENT_00A;
            ENT_00A: stateNx = ENT_01;
            ENT_01:  stateNx = ENT_00B;
            default: stateNx = CMD;
          endcase
        end else begin
          cntNx = cnt + CW'(1);
        end
      end
      CMD: begin
        if (!TxRequestEsc) reqLostNx = 1'b1;
        if (CmdDone) begin
          if (reqLost || !TxRequestEsc) stateNx = EXIT_10;
          else if (grant[0])            stateNx = PAYLOAD;
          else if (grant[1])            stateNx = ULPS;
          else                          stateNx = EXIT_10;
        end
      end
      PAYLOAD: begin
        if (bitCnt != 3'd0) begin
          // A request drop mid-byte is ignored until the last bit is on the line.
          payBitNx = shReg[0];
          shRegNx  = {1'b0, shReg[7:1]};
          bitCntNx = bitCnt - 3'd1;
        end else if (TxValidEsc) begin
          // Loading on the last shift cycle keeps bytes back-to-back.
          payBitNx = TxDataEsc[0];
          shRegNx  = {1'b0, TxDataEsc[7:1]};
          bitCntNx = 3'd7;
          readyNx  = 1'b1;
        end else begin
          payBitNx = 1'b0;
          if (!TxRequestEsc) stateNx = EXIT_10;
        end
      end
      ULPS: begin
        if (!TxRequestEsc) stateNx = EXIT_10;
      end
      EXIT_10: begin
        if (cnt == EXIT_LAST) stateNx = IDLE;
        else                  cntNx   = cnt + CW'(1);
      end
      default: stateNx = IDLE;
    endcase
    if (stateNx != PAYLOAD) payBitNx = 1'b0;
    // Registered outputs are decoded from the next state.
    unique case (stateNx)
      IDLE:    lpNx = 2'b11;
      ENT_10:  lpNx = 2'b10;
      ENT_01:  lpNx = 2'b01;
      EXIT_10: lpNx = 2'b10;
      default: lpNx = 2'b00;
    endcase
  end

  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) begin
      state         <= IDLE;
      grant         <= 8'h00;
      cnt           <= '0;
      reqLost       <= 1'b0;
      shReg         <= 8'h00;
      bitCnt        <= 3'd0;
      EscSeqCtr     <= 8'h00;
      LpState       <= 2'b11;
      SeqSel        <= 1'b0;
      PayBit        <= 1'b0;
      PayActive     <= 1'b0;
      TxReadyEsc    <= 1'b0;
      UlpsActiveNot <= 1'b1;
      Stopstate     <= 1'b1;
    end else begin
      state         <= stateNx;
      grant         <= grantNx;
      cnt           <= cntNx;
      reqLost       <= reqLostNx;
      shReg         <= shRegNx;
      bitCnt        <= bitCntNx;
      EscSeqCtr     <= (stateNx == CMD) ? grantNx : 8'h00;
      LpState       <= lpNx;
      SeqSel        <= (stateNx == CMD);
      PayBit        <= payBitNx;
      PayActive     <= (stateNx == PAYLOAD);
      TxReadyEsc    <= readyNx;
      UlpsActiveNot <= (stateNx != ULPS);
      Stopstate     <= (stateNx == IDLE);
    end
  end

endmodule

// File: tb/tb_esc_mode_controller.sv
module tb_esc_mode_controller;
  logic       TxClkEsc, RstN, TxRequestEsc, TxUlpsEsc, TxLpdtEsc, TxValidEsc, CmdDone;
  logic [3:0] TxTriggerEsc;
  logic [7:0] TxDataEsc;
  logic       TxReadyEsc, SeqSel, PayBit, PayActive, UlpsActiveNot, Stopstate;
  logic [7:0] EscSeqCtr;
  logic [1:0] LpState;

  int nCmp = 0;
  int nErr = 0;

  esc_mode_controller #(.ENTRY_CYC(2), .EXIT_CYC(2)) dut (
    .TxClkEsc(TxClkEsc), .RstN(RstN), .TxRequestEsc(TxRequestEsc), .TxUlpsEsc(TxUlpsEsc),
    .TxLpdtEsc(TxLpdtEsc), .TxTriggerEsc(TxTriggerEsc), .TxDataEsc(TxDataEsc),
    .TxValidEsc(TxValidEsc), .TxReadyEsc(TxReadyEsc), .CmdDone(CmdDone),
    .EscSeqCtr(EscSeqCtr), .LpState(LpState), .SeqSel(SeqSel), .PayBit(PayBit),
    .PayActive(PayActive), .UlpsActiveNot(UlpsActiveNot), .Stopstate(Stopstate)
  );

  initial TxClkEsc = 1'b0;
  always #5 TxClkEsc = ~TxClkEsc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the command select to go nonzero; returns negedges waited or -1.
  task automatic wait_cmd(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge TxClkEsc);
      if (EscSeqCtr !== 8'h00) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Serializer model: called on the negedge after EscSeqCtr first goes nonzero; raises
  // CmdDone so that it is sampled 6 edges after that point. Returns the select seen and
  // how many cycles the select/SeqSel were not stable.
  task automatic serve_cmd(output logic [7:0] v, output int chg);
    v = EscSeqCtr;
    chg = (SeqSel !== 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge TxClkEsc);
      if (EscSeqCtr !== v || SeqSel !== 1'b1) chg++;
    end
    CmdDone = 1'b1;
    @(negedge TxClkEsc);
    CmdDone = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge TxClkEsc);
    nCmp++;
    if ({EscSeqCtr, LpState, SeqSel, PayBit, PayActive, TxReadyEsc, UlpsActiveNot, Stopstate}
        !== {8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      nErr++;
      $display("FAIL reset_vals got esc=%h lp=%b sel=%b pb=%b pa=%b rdy=%b un=%b ss=%b required 00 11 0 0 0 0 1 1",
               EscSeqCtr, LpState, SeqSel, PayBit, PayActive, TxReadyEsc, UlpsActiveNot, Stopstate);
    end
    RstN = 1'b1;
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b11 || Stopstate !== 1'b1) begin
      nErr++;
      $display("FAIL after_reset_idle got lp=%b ss=%b required 11 1", LpState, Stopstate);
    end
  endtask

  task automatic test_noselect();
    int bad = 0;
    TxRequestEsc = 1'b1;
    repeat (5) begin
      @(negedge TxClkEsc);
      if (LpState !== 2'b11 || EscSeqCtr !== 8'h00 || Stopstate !== 1'b1) bad++;
    end
    nCmp++;
    if (bad != 0) begin
      nErr++;
      $display("FAIL noselect_idle got %0d bad cycles (lp=%b esc=%h) required 0", bad, LpState, EscSeqCtr);
    end
    TxRequestEsc = 1'b0;
  endtask

  task automatic test_trigger();
    logic [1:0] lpExp [8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [7:0] v;
    int chg;
    int bad = 0;
    TxRequestEsc = 1'b1;
    TxTriggerEsc = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge TxClkEsc);
      if (i == 0) TxTriggerEsc = 4'b0000;  // selection is latched; later changes ignored
      if (LpState !== lpExp[i]) begin
        bad++;
        $display("FAIL trig_entry_lp[%0d] got %b required %b", i, LpState, lpExp[i]);
      end
    end
    nCmp++;
    if (bad != 0) nErr++;
    @(negedge TxClkEsc);
    serve_cmd(v, chg);
    nCmp++;
    if (v !== 8'b0000_0100 || chg != 0) begin
      nErr++;
      $display("FAIL trig_cmd got esc=%b unstable=%0d required 00000100 0", v, chg);
    end
    TxRequestEsc = 1'b0;
    nCmp++;
    if (EscSeqCtr !== 8'h00 || SeqSel !== 1'b0 || LpState !== 2'b10) begin
      nErr++;
      $display("FAIL trig_cmd_release got esc=%h sel=%b lp=%b required 00 0 10", EscSeqCtr, SeqSel, LpState);
    end
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b10 || Stopstate !== 1'b0) begin
      nErr++;
      $display("FAIL trig_exit2 got lp=%b ss=%b required 10 0", LpState, Stopstate);
    end
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b11 || Stopstate !== 1'b1) begin
      nErr++;
      $display("FAIL trig_stop got lp=%b ss=%b required 11 1", LpState, Stopstate);
    end
  endtask

  // Called in the first IDLE cycle after an exit: request is accepted with one LP-11 cycle.
  task automatic test_back_to_back();
    logic [7:0] v;
    int cyc, chg;
    TxRequestEsc = 1'b1;
    TxTriggerEsc = 4'b0010;
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b10) begin
      nErr++;
      $display("FAIL b2b_accept got lp=%b required 10", LpState);
    end
    wait_cmd(cyc);
    nCmp++;
    if (cyc != 8) begin
      nErr++;
      $display("FAIL b2b_cmd_delay got %0d required 8", cyc);
    end
    serve_cmd(v, chg);
    nCmp++;
    if (v !== 8'b0000_1000 || chg != 0) begin
      nErr++;
      $display("FAIL b2b_cmd got esc=%b unstable=%0d required 00001000 0", v, chg);
    end
    TxRequestEsc = 1'b0;
    TxTriggerEsc = 4'b0000;
    repeat (2) @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b11 || Stopstate !== 1'b1) begin
      nErr++;
      $display("FAIL b2b_stop got lp=%b ss=%b required 11 1", LpState, Stopstate);
    end
  endtask

  task automatic test_ulps();
    logic [7:0] v;
    int cyc, chg;
    int bad = 0;
    TxRequestEsc = 1'b1;
    TxUlpsEsc = 1'b1;
    TxLpdtEsc = 1'b1;
    TxTriggerEsc = 4'b1111;
    wait_cmd(cyc);
    nCmp++;
    if (cyc != 9) begin
      nErr++;
      $display("FAIL ulps_cmd_delay got %0d required 9", cyc);
    end
    serve_cmd(v, chg);
    nCmp++;
    if (v !== 8'b0000_0010 || chg != 0) begin
      nErr++;
      $display("FAIL ulps_grant got esc=%b unstable=%0d required 00000010 0", v, chg);
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge TxClkEsc);
      if (UlpsActiveNot !== 1'b0 || LpState !== 2'b00 || EscSeqCtr !== 8'h00) bad++;
    end
    nCmp++;
    if (bad != 0) begin
      nErr++;
      $display("FAIL ulps_hold got %0d bad cycles (un=%b lp=%b) required 0", bad, UlpsActiveNot, LpState);
    end
    TxRequestEsc = 1'b0;
    TxUlpsEsc = 1'b0;
    TxLpdtEsc = 1'b0;
    TxTriggerEsc = 4'b0000;
    @(negedge TxClkEsc);
    nCmp++;
    if (UlpsActiveNot !== 1'b1 || LpState !== 2'b10) begin
      nErr++;
      $display("FAIL ulps_exit1 got un=%b lp=%b required 1 10", UlpsActiveNot, LpState);
    end
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b10) begin
      nErr++;
      $display("FAIL ulps_exit2 got lp=%b required 10", LpState);
    end
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b11 || Stopstate !== 1'b1) begin
      nErr++;
      $display("FAIL ulps_stop got lp=%b ss=%b required 11 1", LpState, Stopstate);
    end
  endtask

  task automatic test_lpdt();
    logic [7:0] v;
    logic [15:0] bits, rdy;
    int cyc, chg;
    int got = -1;
    int paBad = 0;
    TxRequestEsc = 1'b1;
    TxLpdtEsc = 1'b1;
    TxDataEsc = 8'hA5;
    TxValidEsc = 1'b1;
    wait_cmd(cyc);
    serve_cmd(v, chg);
    nCmp++;
    if (v !== 8'b0000_0001 || chg != 0) begin
      nErr++;
      $display("FAIL lpdt_grant got esc=%b unstable=%0d required 00000001 0", v, chg);
    end
    for (int k = 0; k < 10; k++) begin
      if (TxReadyEsc === 1'b1) begin
        got = k;
        break;
      end
      @(negedge TxClkEsc);
    end
    nCmp++;
    if (got != 1) begin
      nErr++;
      $display("FAIL lpdt_first_ready got cycle %0d required 1", got);
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge TxClkEsc);
      bits[i] = PayBit;
      rdy[i] = TxReadyEsc;
      if (PayActive !== 1'b1) paBad++;
      if (i == 0) TxDataEsc = 8'h3C;
      if (i == 8) begin
        TxValidEsc = 1'b0;
        TxRequestEsc = 1'b0;  // drop mid-byte: second byte must still finish
      end
    end
    nCmp++;
    if (bits !== 16'h3CA5) begin
      nErr++;
      $display("FAIL lpdt_paybits got %h required 3ca5 (LSB first)", bits);
    end
    nCmp++;
    if (rdy !== 16'h0101 || paBad != 0) begin
      nErr++;
      $display("FAIL lpdt_ready got %h payactive_bad=%0d required 0101 0", rdy, paBad);
    end
    @(negedge TxClkEsc);
    nCmp++;
    if (PayActive !== 1'b0 || PayBit !== 1'b0 || LpState !== 2'b10) begin
      nErr++;
      $display("FAIL lpdt_exit got pa=%b pb=%b lp=%b required 0 0 10", PayActive, PayBit, LpState);
    end
    TxLpdtEsc = 1'b0;
    repeat (2) @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b11 || Stopstate !== 1'b1) begin
      nErr++;
      $display("FAIL lpdt_stop got lp=%b ss=%b required 11 1", LpState, Stopstate);
    end
  endtask

  task automatic test_drop_entry();
    logic [7:0] v;
    int cyc, chg;
    int bad = 0;
    TxRequestEsc = 1'b1;
    TxLpdtEsc = 1'b1;
    TxValidEsc = 1'b1;
    TxDataEsc = 8'h55;
    repeat (5) @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b01) begin
      nErr++;
      $display("FAIL drop_in_ent01 got lp=%b required 01", LpState);
    end
    TxRequestEsc = 1'b0;
    wait_cmd(cyc);
    nCmp++;
    if (cyc != 4) begin
      nErr++;
      $display("FAIL drop_cmd_delay got %0d required 4", cyc);
    end
    serve_cmd(v, chg);
    nCmp++;
    if (v !== 8'b0000_0001 || chg != 0) begin
      nErr++;
      $display("FAIL drop_cmd got esc=%b unstable=%0d required 00000001 0", v, chg);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge TxClkEsc);
      if (PayActive !== 1'b0 || TxReadyEsc !== 1'b0) bad++;
      if (LpState !== ((i < 2) ? 2'b10 : 2'b11)) bad++;
    end
    nCmp++;
    if (bad != 0) begin
      nErr++;
      $display("FAIL drop_exit got %0d bad samples (pa=%b lp=%b) required 0", bad, PayActive, LpState);
    end
    TxLpdtEsc = 1'b0;
    TxValidEsc = 1'b0;
  endtask

  task automatic test_reset_payload();
    logic [7:0] v;
    int cyc, chg;
    TxRequestEsc = 1'b1;
    TxLpdtEsc = 1'b1;
    TxValidEsc = 1'b0;
    wait_cmd(cyc);
    serve_cmd(v, chg);
    @(negedge TxClkEsc);
    nCmp++;
    if (PayActive !== 1'b1 || PayBit !== 1'b0 || TxReadyEsc !== 1'b0) begin
      nErr++;
      $display("FAIL pay_wait got pa=%b pb=%b rdy=%b required 1 0 0", PayActive, PayBit, TxReadyEsc);
    end
    TxDataEsc = 8'h06;
    TxValidEsc = 1'b1;
    @(negedge TxClkEsc);
    TxValidEsc = 1'b0;
    @(negedge TxClkEsc);
    nCmp++;
    if (PayBit !== 1'b1 || PayActive !== 1'b1) begin
      nErr++;
      $display("FAIL pay_midbyte got pb=%b pa=%b required 1 1", PayBit, PayActive);
    end
    #2 RstN = 1'b0;
    #1;
    nCmp++;
    if ({EscSeqCtr, LpState, SeqSel, PayBit, PayActive, TxReadyEsc, UlpsActiveNot, Stopstate}
        !== {8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      nErr++;
      $display("FAIL async_reset got esc=%h lp=%b sel=%b pb=%b pa=%b rdy=%b un=%b ss=%b required 00 11 0 0 0 0 1 1",
               EscSeqCtr, LpState, SeqSel, PayBit, PayActive, TxReadyEsc, UlpsActiveNot, Stopstate);
    end
    TxRequestEsc = 1'b0;
    TxLpdtEsc = 1'b0;
    @(negedge TxClkEsc);
    RstN = 1'b1;
    @(negedge TxClkEsc);
    TxRequestEsc = 1'b1;
    TxTriggerEsc = 4'b0100;
    @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b10 || PayActive !== 1'b0) begin
      nErr++;
      $display("FAIL restart_ent10 got lp=%b pa=%b required 10 0", LpState, PayActive);
    end
    wait_cmd(cyc);
    serve_cmd(v, chg);
    nCmp++;
    if (cyc != 8 || v !== 8'b0001_0000 || chg != 0) begin
      nErr++;
      $display("FAIL restart_cmd got delay=%0d esc=%b unstable=%0d required 8 00010000 0", cyc, v, chg);
    end
    TxRequestEsc = 1'b0;
    TxTriggerEsc = 4'b0000;
    repeat (2) @(negedge TxClkEsc);
    nCmp++;
    if (LpState !== 2'b11 || Stopstate !== 1'b1) begin
      nErr++;
      $display("FAIL restart_stop got lp=%b ss=%b required 11 1", LpState, Stopstate);
    end
  endtask

  initial begin
    RstN = 1'b0;
    TxRequestEsc = 1'b0;
    TxUlpsEsc = 1'b0;
    TxLpdtEsc = 1'b0;
    TxTriggerEsc = 4'b0000;
    TxDataEsc = 8'h00;
    TxValidEsc = 1'b0;
    CmdDone = 1'b0;
    test_reset();
    test_noselect();
    @(negedge TxClkEsc);
    test_trigger();
    test_back_to_back();
    @(negedge TxClkEsc);
    test_ulps();
    @(negedge TxClkEsc);
    test_lpdt();
    @(negedge TxClkEsc);
    test_drop_entry();
    @(negedge TxClkEsc);
    test_reset_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
